// File: rtl/dmx_rx.sv
// DMX-512 receiver: 16x oversampled 8N2 framing with BREAK detection.
// Each delivered slot appears on data/slot together with a 1-cycle valid pulse; the start code
// (slot 0) is tagged in data[8]. Slots are dropped until a BREAK has been seen.
module dmx_rx #(
    parameter int unsigned BRK_BITS = 22,
    parameter int unsigned MAX_SLOT = 512
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baudEn,
    input  logic       rxd,
    output logic [8:0] data,
    output logic [9:0] slot,
    output logic       valid,
    output logic       brk,
    output logic       ferr,
    output logic       ovf
);

    localparam int unsigned RunMax = BRK_BITS * 16;
    localparam int unsigned RunW   = $clog2(RunMax + 1);
    localparam logic [RunW-1:0] RunMaxV  = RunW'(RunMax);
    localparam logic [9:0]      MaxSlotV = 10'(MAX_SLOT);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop1,
        StStop2,
        StWaitH
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic [3:0]      ph_q, ph_d;
    logic [2:0]      bitn_q, bitn_d;
    logic [7:0]      shift_q, shift_d;
    logic [RunW-1:0] run_q, run_d;
    logic [9:0]      next_q, next_d;
    logic            synced_q, synced_d;
    logic [8:0]      data_q, data_d;
    logic [9:0]      slot_q, slot_d;
    logic            valid_q, valid_d;
    logic            brk_q, brk_d;
    logic            ferr_q, ferr_d;
    logic            ovf_q, ovf_d;
    logic            rxs;

    assign rxs   = sync_q[1];
    assign data  = data_q;
    assign slot  = slot_q;
    assign valid = valid_q;
    assign brk   = brk_q;
    assign ferr  = ferr_q;
    assign ovf   = ovf_q;

    // Two-flop synchronizer for the asynchronous line; idles high out of reset.
    always_comb begin
        sync_d = {sync_q[0], rxd};
    end

    // Next-state logic: everything but the synchronizer and pulse clearing waits for baudEn.
    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        bitn_d   = bitn_q;
        shift_d  = shift_q;
        run_d    = run_q;
        next_d   = next_q;
        synced_d = synced_q;
        data_d   = data_q;
        slot_d   = slot_q;
        valid_d  = 1'b0;
        brk_d    = 1'b0;
        ferr_d   = 1'b0;
        ovf_d    = 1'b0;

        if (baudEn) begin
            // Low-time measurement used to tell a BREAK from a framing error.
            if (rxs) begin
                run_d = '0;
            end else if (run_q != RunMaxV) begin
                run_d = run_q + 1'b1;
            end

            // Phase free-runs from start-bit detection; every decision is made at ph=7,
            // i.e. mid-bit, so one full bit separates consecutive samples.
            ph_d = ph_q + 4'd1;

            case (state_q)
                StIdle: begin
                    if (!rxs) begin
                        state_d = StStart;
                        ph_d    = '0;
                    end
                end
                StStart: begin
                    if (ph_q == 4'd7) begin
                        if (rxs) begin
                            state_d = StIdle;
                        end else begin
                            state_d = StData;
                            bitn_d  = '0;
                        end
                    end
                end
                StData: begin
                    if (ph_q == 4'd7) begin
                        shift_d = {rxs, shift_q[7:1]};
                        bitn_d  = bitn_q + 3'd1;
                        if (bitn_q == 3'd7) begin
                            state_d = StStop1;
                        end
                    end
                end
                StStop1: begin
                    if (ph_q == 4'd7) begin
                        state_d = rxs ? StStop2 : StWaitH;
                    end
                end
                StStop2: begin
                    if (ph_q == 4'd7) begin
                        if (rxs) begin
                            state_d = StIdle;
                            if (synced_q) begin
                                if (next_q <= MaxSlotV) begin
                                    data_d  = {(next_q == 10'd0), shift_q};
                                    slot_d  = next_q;
                                    valid_d = 1'b1;
                                    next_d  = next_q + 10'd1;
                                end else begin
                                    ovf_d = 1'b1;
                                end
                            end
                        end else begin
                            state_d = StWaitH;
                        end
                    end
                end
                StWaitH: begin
                    // Classified only once the line returns high.
                    if (rxs) begin
                        state_d = StIdle;
                        if (run_q >= RunMaxV) begin
                            brk_d    = 1'b1;
                            synced_d = 1'b1;
                            next_d   = '0;
                        end else begin
                            ferr_d   = 1'b1;
                            synced_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            sync_q   <= 2'b11;
            ph_q     <= '0;
            bitn_q   <= '0;
            shift_q  <= '0;
            run_q    <= '0;
            next_q   <= '0;
            synced_q <= 1'b0;
            data_q   <= '0;
            slot_q   <= '0;
            valid_q  <= 1'b0;
            brk_q    <= 1'b0;
            ferr_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            ph_q     <= ph_d;
            bitn_q   <= bitn_d;
            shift_q  <= shift_d;
            run_q    <= run_d;
            next_q   <= next_d;
            synced_q <= synced_d;
            data_q   <= data_d;
            slot_q   <= slot_d;
            valid_q  <= valid_d;
            brk_q    <= brk_d;
            ferr_q   <= ferr_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule
